// File: rtl/dmg_timer.sv
// Game Boy timer: TIMA/TMA/TAC registers at FF05-FF07 plus the FF04 DIV port.
// TIMA counts falling edges of a TAC-selected divider tap; overflow triggers a delayed TMA reload and irq.
module dmg_timer #(
  parameter int RELOAD_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] div,
  input  logic        ff04_ff07,
  input  logic [1:0]  addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic        div_reset,
  output logic        irq_timer,
  output logic [7:0]  tima_q
);

  // state  | meaning
  // IDLE   | TIMA counts selected tap falling edges
  // OVF    | TIMA overflowed, reads 0x00 while the reload delay runs down
  // RELOAD | one cycle after the TMA load; TIMA writes ignored, TMA writes pass through
  typedef enum logic [1:0] {IDLE, OVF, RELOAD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  tima, tima_nxt;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic [3:0]  cnt, cnt_nxt;
  logic        irq_nxt;
  logic        tap_bit, tap, tap_prev, inc;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  assign wr_div  = cpu_wr && ff04_ff07 && (addr == 2'd0);
  assign wr_tima = cpu_wr && ff04_ff07 && (addr == 2'd1);
  assign wr_tma  = cpu_wr && ff04_ff07 && (addr == 2'd2);
  assign wr_tac  = cpu_wr && ff04_ff07 && (addr == 2'd3);

  always_comb begin
    case (tac[1:0])
      2'd0:    tap_bit = div[9];
      2'd1:    tap_bit = div[3];
      2'd2:    tap_bit = div[5];
      default: tap_bit = div[7];
    endcase
  end

  // Disabling or reselecting the tap can itself create a falling edge; that is intentional.
  assign tap = tap_bit & tac[2];
  assign inc = tap_prev & ~tap;

  always_comb begin
    state_nxt = state;
    tima_nxt  = tima;
    cnt_nxt   = cnt;
    irq_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_nxt = wdata;
        end else if (inc) begin
          if (tima == 8'hFF) begin
            tima_nxt  = 8'h00;
            cnt_nxt   = 4'(RELOAD_DELAY - 1);
            state_nxt = OVF;
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_nxt  = wdata;
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          tima_nxt  = wr_tma ? wdata : tma;
          irq_nxt   = 1'b1;
          state_nxt = RELOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RELOAD: begin
        if (wr_tma) tima_nxt = wdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tima      <= 8'h00;
      tma       <= 8'h00;
      tac       <= 3'b000;
      cnt       <= 4'd0;
      tap_prev  <= 1'b0;
      irq_timer <= 1'b0;
      div_reset <= 1'b0;
    end else begin
      state     <= state_nxt;
      tima      <= tima_nxt;
      cnt       <= cnt_nxt;
      tap_prev  <= tap;
      irq_timer <= irq_nxt;
      div_reset <= wr_div;
      if (wr_tma) tma <= wdata;
      if (wr_tac) tac <= wdata[2:0];
    end
  end

  assign tima_q   = tima;
  assign rdata_oe = ff04_ff07 && cpu_rd;

  always_comb begin
    rdata = 8'h00;
    if (rdata_oe) begin
      case (addr)
        2'd0:    rdata = div[15:8];
        2'd1:    rdata = tima;
        2'd2:    rdata = tma;
        default: rdata = {5'b11111, tac};
      endcase
    end
  end

endmodule

// File: tb/tb_dmg_timer.sv
// Bench for dmg_timer: directed scenarios plus randomized traffic against a cycle-indexed reference model.
module tb_dmg_timer;

  localparam int D = 4;
  localparam int TAP_BIT [4] = '{9, 3, 5, 7};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] div = 16'h0000;
  logic        ff04_ff07 = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata, rdata1, tima_q, tima1;
  logic        rdata_oe, rdata_oe1, div_reset, div_reset1, irq_timer, irq1;

  int n_cmp = 0;
  int n_err = 0;
  bit div_auto = 1'b0;

  // reference model state
  int          cyc = 0;
  int          ovf_at = -1;
  int          last_reload = -10;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  logic        m_tap_prev, m_irq, m_divrst;

  dmg_timer #(.RELOAD_DELAY(D)) u_dut (
    .clk(clk), .reset(reset), .div(div), .ff04_ff07(ff04_ff07), .addr(addr),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe),
    .div_reset(div_reset), .irq_timer(irq_timer), .tima_q(tima_q)
  );

  dmg_timer #(.RELOAD_DELAY(1)) u_dut1 (
    .clk(clk), .reset(reset), .div(div), .ff04_ff07(ff04_ff07), .addr(addr),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .wdata(wdata), .rdata(rdata1), .rdata_oe(rdata_oe1),
    .div_reset(div_reset1), .irq_timer(irq1), .tima_q(tima1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic tap_of(input logic [15:0] d, input logic [2:0] t);
    return d[TAP_BIT[t[1:0]]] & t[2];
  endfunction

  task automatic model_clear();
    m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
    m_tap_prev = 1'b0; m_irq = 1'b0; m_divrst = 1'b0;
    ovf_at = -1; last_reload = -10;
  endtask

  // Reload happens D edges after the overflow edge; the edge after a reload is the RELOAD cycle.
  task automatic model_step();
    logic t, inc, wr_any;
    wr_any = cpu_wr && ff04_ff07;
    t = tap_of(div, m_tac);
    inc = m_tap_prev && !t;
    m_irq = 1'b0;
    if (ovf_at >= 0) begin
      if (wr_any && addr == 2'd1) begin
        m_tima = wdata; ovf_at = -1;
      end else if (cyc == ovf_at + D) begin
        m_tima = (wr_any && addr == 2'd2) ? wdata : m_tma;
        m_irq = 1'b1; last_reload = cyc; ovf_at = -1;
      end
    end else if (cyc == last_reload + 1) begin
      if (wr_any && addr == 2'd2) m_tima = wdata;
    end else begin
      if (wr_any && addr == 2'd1) m_tima = wdata;
      else if (inc) begin
        if (m_tima == 8'hFF) begin m_tima = 8'h00; ovf_at = cyc; end
        else m_tima = m_tima + 8'd1;
      end
    end
    if (wr_any && addr == 2'd2) m_tma = wdata;
    if (wr_any && addr == 2'd3) m_tac = wdata[2:0];
    m_divrst = wr_any && (addr == 2'd0);
    m_tap_prev = t;
    cyc++;
  endtask

  function automatic logic [7:0] exp_rdata();
    if (!(ff04_ff07 && cpu_rd)) return 8'h00;
    case (addr)
      2'd0:    return div[15:8];
      2'd1:    return m_tima;
      2'd2:    return m_tma;
      default: return {5'b11111, m_tac};
    endcase
  endfunction

  task automatic tick();
    #1;
    chk("rdata", rdata, exp_rdata());
    chk("rdata_oe", rdata_oe, ff04_ff07 && cpu_rd);
    model_step();
    @(posedge clk);
    #1;
    chk("tima", tima_q, m_tima);
    chk("irq", irq_timer, m_irq);
    chk("div_reset", div_reset, m_divrst);
    if (div_auto) div = div_reset ? 16'h0000 : div + 16'd1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    ff04_ff07 = 1'b1; addr = a; wdata = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0; ff04_ff07 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_tima", tima_q, 8'h00);
    chk("rst_irq", irq_timer, 1'b0);
    chk("rst_divrst", div_reset, 1'b0);
    chk("rst_tima1", tima1, 8'h00);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cpu_wr = 1'b0; cpu_rd = 1'b0; ff04_ff07 = 1'b0;
  endtask

  task automatic wait_tima(input string tag, input logic [7:0] val, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (tima_q == val) break;
      tick();
    end
    chk({"wait_", tag}, tima_q, val);
  endtask

  initial begin
    model_clear();
    #2;
    do_reset();

    // overflow from TIMA=0xFE with div sweeping from 0, TMA=0
    wr(2'd3, 8'h05);
    wr(2'd1, 8'hFE);
    div = 16'h0000; div_auto = 1'b1;
    wait_tima("t1_ff", 8'hFF, 40);
    wait_tima("t1_00", 8'h00, 40);
    tickn(3);
    chk("t1_irq_early", irq_timer, 1'b0);
    tick();
    chk("t1_irq", irq_timer, 1'b1);
    chk("t1_tima", tima_q, 8'h00);

    // TMA=0x80 reload, compared against RELOAD_DELAY=1 instance
    do_reset();
    div_auto = 1'b0; div = 16'h0000;
    wr(2'd3, 8'h05);
    wr(2'd2, 8'h80);
    wr(2'd1, 8'hFF);
    div_auto = 1'b1;
    wait_tima("t2_00", 8'h00, 40);
    chk("t2_d1_ovf", tima1, 8'h00);
    tick();
    chk("t2_d1_tima", tima1, 8'h80);
    chk("t2_d1_irq", irq1, 1'b1);
    chk("t2_tima_e1", tima_q, 8'h00);
    tickn(2);
    chk("t2_tima_e3", tima_q, 8'h00);
    tick();
    chk("t2_tima", tima_q, 8'h80);
    chk("t2_irq", irq_timer, 1'b1);
    tick();
    chk("t2_irq_once", irq_timer, 1'b0);

    // TIMA write inside the overflow window cancels the reload
    wr(2'd1, 8'hFF);
    wait_tima("t3_00", 8'h00, 40);
    tick();
    wr(2'd1, 8'h42);
    chk("t3_tima", tima_q, 8'h42);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_noirq", irq_timer, 1'b0);
    end
    chk("t3_hold", tima_q, 8'h42);

    // TIMA write in the RELOAD cycle is ignored
    wr(2'd1, 8'hFF);
    wait_tima("t3b_00", 8'h00, 40);
    tickn(4);
    chk("t3b_reload", tima_q, 8'h80);
    wr(2'd1, 8'h11);
    chk("t3b_ignored", tima_q, 8'h80);

    // TMA write in the RELOAD cycle also lands in TIMA
    wr(2'd1, 8'hFF);
    wait_tima("t4_00", 8'h00, 40);
    tickn(4);
    wr(2'd2, 8'h33);
    chk("t4_tima", tima_q, 8'h33);
    ff04_ff07 = 1'b1; cpu_rd = 1'b1; addr = 2'd2;
    #1;
    chk("t4_tma_rd", rdata, 8'h33);
    cpu_rd = 1'b0; ff04_ff07 = 1'b0;

    // FF04 write: single div_reset pulse
    wr(2'd0, 8'h5A);
    chk("t4_divrst_hi", div_reset, 1'b1);
    tick();
    chk("t4_divrst_lo", div_reset, 1'b0);

    // clearing div with the tap high counts once
    div_auto = 1'b0; div = 16'h0008;
    wr(2'd1, 8'h10);
    tick();
    div = 16'h0000;
    tick();
    chk("t4_divclr_inc", tima_q, 8'h11);

    // TAC disable and TAC reselect with tap high each count once
    div = 16'h0008;
    wr(2'd3, 8'h05);
    tick();
    wr(2'd3, 8'h01);
    tick();
    chk("t5_disable_inc", tima_q, 8'h12);
    wr(2'd3, 8'h05);
    tick();
    wr(2'd3, 8'h06);
    tick();
    chk("t5_resel_inc", tima_q, 8'h13);

    // reads
    wr(2'd3, 8'h05);
    div = 16'hA5C8;
    ff04_ff07 = 1'b1; cpu_rd = 1'b1;
    addr = 2'd0; #1; chk("rd_div", rdata, 8'hA5);
    addr = 2'd1; #1; chk("rd_tima", rdata, 8'h13);
    addr = 2'd2; #1; chk("rd_tma", rdata, 8'h33);
    addr = 2'd3; #1; chk("rd_tac", rdata, 8'hFD);
    cpu_rd = 1'b0; #1; chk("rd_none", rdata, 8'h00);
    chk("rd_oe_low", rdata_oe, 1'b0);
    ff04_ff07 = 1'b0; cpu_rd = 1'b1; #1; chk("rd_nosel", rdata, 8'h00);
    cpu_rd = 1'b0;
    tick();

    // reset in the middle of OVF aborts the reload
    wr(2'd1, 8'hFF);
    div = 16'h0000;
    tick();
    chk("t6_ovf", tima_q, 8'h00);
    tick();
    do_reset();
    div_auto = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_noirq", irq_timer, 1'b0);
    end

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      cpu_rd = $urandom_range(0, 1);
      addr = 2'($urandom_range(0, 3));
      ff04_ff07 = ($urandom_range(0, 7) != 0);
      cpu_wr = ($urandom_range(0, 5) == 0);
      wdata = 8'($urandom);
      if (addr == 2'd1 && $urandom_range(0, 1) == 1) wdata = $urandom_range(0, 1) ? 8'hFF : 8'hFE;
      if (addr == 2'd3 && $urandom_range(0, 3) != 0) wdata = {5'b00000, 1'b1, 2'($urandom_range(1, 2))};
      if (addr == 2'd0 && $urandom_range(0, 3) != 0) cpu_wr = 1'b0;
      tick();
      cpu_wr = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
